// File: rtl/tt_seq_addsub_acc_if.sv
// Request/result bundle for the slice-serial adder/subtractor core.
// The core connects through the slave modport; the requester uses master.
interface tt_seq_addsub_acc_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry_in;
  logic             sub;
  logic             acc;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport slave (
    input  in_valid, op_a, op_b, carry_in, sub, acc, acc_clr, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, busy
  );

  modport master (
    output in_valid, op_a, op_b, carry_in, sub, acc, acc_clr, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/tt_seq_addsub_acc.sv
// Slice-serial adder/subtractor with running accumulator.
// Operands are shifted right SLICE bits per RUN cycle; the result is
// shifted in from the top of a working register and copied to the
// visible outputs only when the last slice completes.
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | waiting for a request, in_ready high
// RUN    | one slice per cycle, LSB slice first
// DONE   | result presented, waiting for out_ready
module tt_seq_addsub_acc #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  tt_seq_addsub_acc_if.slave   bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $error("tt_seq_addsub_acc: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_c;
  logic             r_a_msb;
  logic             r_bx_msb;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_bx;
  logic [SLICE:0]   w_slice_sum;
  logic [WIDTH-1:0] w_work_next;
  logic             w_last;

  // A clear in the accept cycle wins over the stored accumulator value.
  assign w_a_sel = bus.acc ? (bus.acc_clr ? '0 : r_acc) : bus.op_a;
  assign w_bx    = bus.sub ? ~bus.op_b : bus.op_b;

  assign w_slice_sum = {1'b0, r_a[SLICE-1:0]} + {1'b0, r_bx[SLICE-1:0]}
                     + {{SLICE{1'b0}}, r_c};
  assign w_work_next = (r_work >> SLICE)
                     | (WIDTH'(w_slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
  assign w_last      = (r_cnt == CW'(NSL - 1));

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;

  // Sequencer, slice datapath and result/accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_a         <= '0;
      r_bx        <= '0;
      r_c         <= 1'b0;
      r_a_msb     <= 1'b0;
      r_bx_msb    <= 1'b0;
      r_work      <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.acc_clr) r_acc <= '0;
          if (bus.in_valid) begin
            r_a      <= w_a_sel;
            r_a_msb  <= w_a_sel[WIDTH-1];
            r_bx     <= w_bx;
            r_bx_msb <= w_bx[WIDTH-1];
            r_c      <= bus.sub ^ bus.carry_in;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_a    <= r_a >> SLICE;
          r_bx   <= r_bx >> SLICE;
          r_c    <= w_slice_sum[SLICE];
          r_work <= w_work_next;
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum       <= w_work_next;
            r_cout      <= w_slice_sum[SLICE];
            r_ovf       <= (r_a_msb == r_bx_msb) & (w_work_next[WIDTH-1] != r_a_msb);
            r_acc       <= w_work_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_seq_addsub_acc.sv
// Directed bench for tt_seq_addsub_acc (WIDTH=16, SLICE=4).
module tb_tt_seq_addsub_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_seq_addsub_acc_if #(.WIDTH(16)) bus();

  tt_seq_addsub_acc #(.WIDTH(16), .SLICE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Last result the outputs are expected to be holding.
  logic [15:0] held_sum = 16'h0000;
  logic        held_c   = 1'b0;
  logic        held_o   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic s, input logic ac, input logic clr,
                       input logic [15:0] es, input logic ec, input logic eo,
                       input int hold, input logic clr_in_run);
    int lat;
    lat = 0;
    while (bus.in_ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk($sformatf("%s/ready_before", tag), bus.in_ready, 1);
    bus.op_a      = a;
    bus.op_b      = b;
    bus.carry_in  = cin;
    bus.sub       = s;
    bus.acc       = ac;
    bus.acc_clr   = clr;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    tick();
    // scramble inputs: the core must not re-sample them during RUN
    bus.in_valid = 1'b0;
    bus.acc_clr  = clr_in_run;
    bus.op_a     = 16'($urandom);
    bus.op_b     = 16'($urandom);
    bus.sub      = ~s;
    bus.carry_in = ~cin;
    bus.acc      = ~ac;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      chk($sformatf("%s/run_in_ready", tag), bus.in_ready, 0);
      chk($sformatf("%s/run_busy", tag), bus.busy, 1);
      chk($sformatf("%s/run_sum_held", tag), bus.sum, held_sum);
      chk($sformatf("%s/run_cout_held", tag), bus.carry_out, held_c);
      chk($sformatf("%s/run_ovf_held", tag), bus.overflow, held_o);
      tick();
      lat++;
    end
    bus.acc_clr = 1'b0;
    chk($sformatf("%s/latency", tag), lat, 5);
    chk($sformatf("%s/sum", tag), bus.sum, es);
    chk($sformatf("%s/carry_out", tag), bus.carry_out, ec);
    chk($sformatf("%s/overflow", tag), bus.overflow, eo);
    held_sum = es;
    held_c   = ec;
    held_o   = eo;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = (i % 2) == 0;
      bus.op_a     = 16'h0BAD;
      tick();
      chk($sformatf("%s/bp_out_valid", tag), bus.out_valid, 1);
      chk($sformatf("%s/bp_sum", tag), bus.sum, es);
      chk($sformatf("%s/bp_cout", tag), bus.carry_out, ec);
      chk($sformatf("%s/bp_ovf", tag), bus.overflow, eo);
      chk($sformatf("%s/bp_in_ready", tag), bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk($sformatf("%s/post_out_valid", tag), bus.out_valid, 0);
    chk($sformatf("%s/post_in_ready", tag), bus.in_ready, 1);
    chk($sformatf("%s/post_sum_kept", tag), bus.sum, es);
    tick();
    chk($sformatf("%s/not_queued", tag), bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op_a      = 16'h0000;
    bus.op_b      = 16'h0000;
    bus.carry_in  = 1'b0;
    bus.sub       = 1'b0;
    bus.acc       = 1'b0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset/out_valid", bus.out_valid, 0);
    chk("reset/sum", bus.sum, 16'h0000);
    chk("reset/carry_out", bus.carry_out, 0);
    chk("reset/overflow", bus.overflow, 0);
    chk("reset/busy", bus.busy, 0);
    chk("reset/in_ready", bus.in_ready, 1);

    //     tag         a         b         cin  sub  acc  clr  sum       c     o     hold clr_run
    do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 0, 1'b0);
    do_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    do_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1'b0);
    do_op("add_cin",   16'h0FFF, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 0, 1'b0);
    do_op("sub_bin",   16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0, 0, 1'b0);

    // accumulator now 0xFFFF; clear it while idle
    bus.acc_clr = 1'b1;
    tick();
    bus.acc_clr = 1'b0;
    do_op("acc_1",     16'hDEAD, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 0, 1'b0);
    do_op("acc_2",     16'hDEAD, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 0, 1'b0);
    do_op("acc_3",     16'hDEAD, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0030, 1'b0, 1'b0, 0, 1'b0);
    do_op("acc_plain", 16'h0100, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0, 0, 1'b0);
    do_op("acc_read",  16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 0, 1'b0);
    do_op("acc_clracc",16'hBEEF, 16'h0005, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b0, 0, 1'b0);
    do_op("acc_clrrun",16'hBEEF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 0, 1'b1);
    do_op("acc_kept",  16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0006, 1'b0, 1'b0, 0, 1'b0);

    do_op("backpress", 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 10, 1'b0);
    do_op("acc_sub",   16'h0000, 16'h0010, 1'b0, 1'b1, 1'b1, 1'b0, 16'h3323, 1'b1, 1'b0, 0, 1'b0);

    // reset two cycles into an operation; accumulator holds 0x3323 beforehand
    bus.op_a     = 16'hFFFF;
    bus.op_b     = 16'h0001;
    bus.carry_in = 1'b0;
    bus.sub      = 1'b0;
    bus.acc      = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("abort/busy_before", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort/out_valid", bus.out_valid, 0);
    chk("abort/sum", bus.sum, 16'h0000);
    chk("abort/carry_out", bus.carry_out, 0);
    chk("abort/overflow", bus.overflow, 0);
    chk("abort/busy", bus.busy, 0);
    chk("abort/in_ready", bus.in_ready, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort/no_result", bus.out_valid, 0);
    end
    held_sum = 16'h0000;
    held_c   = 1'b0;
    held_o   = 1'b0;
    do_op("abort_acc0",16'hBEEF, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
